// File: rtl/mmio_controller.sv
// Memory-access sequencer and LC-3 device-register decoder (KBSR/KBDR/DSR/DDR/MCR) in front of MAR/MDR memory.
// Latency: device access gives mem_ready 1 cycle after the mem_en sample; RAM access gives it MEM_LATENCY cycles after.
// Backpressure: one access at a time, mar/mdr held from mem_en through DONE; the display holds disp_valid until disp_ready.
//
// Ports: clk/reset (async active-low); mar/mdr/mem_en/r_w from the datapath and control FSM;
//        mem_ready/mem_we/sel_mdr/io_data back to the Memory block; kb_data/kb_valid keyboard input;
//        disp_data/disp_valid/disp_ready display handshake; run = MCR[15] datapath clock enable.
// Optional macro MMIO_IRQ_EN: adds KBSR[14]/DSR[14] interrupt enables and a registered irq output.
module mmio_controller #(
    parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
    parameter logic [15:0] DSR_ADDR    = 16'hFE04,
    parameter logic [15:0] DDR_ADDR    = 16'hFE06,
    parameter logic [15:0] MCR_ADDR    = 16'hFFFE,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mar,
    input  logic [15:0] mdr,
    input  logic        mem_en,
    input  logic        r_w,
    output logic        mem_ready,
    output logic        mem_we,
    output logic [1:0]  sel_mdr,
    output logic [15:0] io_data,
    input  logic [7:0]  kb_data,
    input  logic        kb_valid,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic        run
`ifdef MMIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // WAIT is entered with MEM_LATENCY-2 so DONE is reached MEM_LATENCY-1 edges after the sample.
    localparam logic [3:0] CNT_INIT = 4'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic        r_io;
    logic        r_mem_ready;
    logic        r_mem_we;
    logic        r_kb_rdy;
    logic [7:0]  r_kbdr;
    logic        r_dsr_rdy;
    logic [7:0]  r_disp_data;
    logic        r_disp_valid;
    logic [15:0] r_mcr;

    logic        w_is_io;
    logic        w_done;
    logic        w_dev_wr;
    logic        w_kbdr_rd;
    logic        w_ddr_wr;
    logic        w_mcr_wr;
    logic        w_kb_ie;
    logic        w_dsr_ie;
    logic [15:0] w_io_data;

    assign w_is_io = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) || (mar == DSR_ADDR) ||
                     (mar == DDR_ADDR)  || (mar == MCR_ADDR);

    // Device side effects happen on the edge that leaves DONE; mar/mdr are still held then.
    assign w_done    = (r_state == DONE);
    assign w_dev_wr  = w_done && r_io && r_wr;
    assign w_kbdr_rd = w_done && r_io && !r_wr && (mar == KBDR_ADDR);
    assign w_ddr_wr  = w_dev_wr && (mar == DDR_ADDR) && r_dsr_rdy;
    assign w_mcr_wr  = w_dev_wr && (mar == MCR_ADDR);

    always_comb begin
        w_io_data = '0;
        if (mar == KBSR_ADDR)      w_io_data = {r_kb_rdy, w_kb_ie, 14'b0};
        else if (mar == KBDR_ADDR) w_io_data = {8'h00, r_kbdr};
        else if (mar == DSR_ADDR)  w_io_data = {r_dsr_rdy, w_dsr_ie, 14'b0};
        else if (mar == MCR_ADDR)  w_io_data = r_mcr;
    end

    assign sel_mdr    = w_is_io ? 2'b11 : 2'b01;
    assign io_data    = w_io_data;
    assign mem_ready  = r_mem_ready;
    assign mem_we     = r_mem_we;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign run        = r_mcr[15];

    // Access sequencer; mem_ready/mem_we are registered and high only while in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_io        <= 1'b0;
            r_mem_ready <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_ready <= 1'b0;
            r_mem_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_en) begin
                        r_wr <= r_w;
                        r_io <= w_is_io;
                        if (w_is_io || (MEM_LATENCY == 1)) begin
                            r_state     <= DONE;
                            r_mem_ready <= 1'b1;
                            r_mem_we    <= r_w && !w_is_io;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= DONE;
                        r_mem_ready <= 1'b1;
                        r_mem_we    <= r_wr && !r_io;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Device registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kb_rdy     <= 1'b0;
            r_kbdr       <= '0;
            r_dsr_rdy    <= 1'b1;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_mcr        <= 16'h8000;
        end else begin
            if (w_kbdr_rd)
                r_kb_rdy <= 1'b0;
            // A character arriving on the KBDR-read edge is kept: set beats clear.
            if (kb_valid && (!r_kb_rdy || w_kbdr_rd)) begin
                r_kbdr   <= kb_data;
                r_kb_rdy <= 1'b1;
            end

            if (w_ddr_wr) begin
                r_disp_data  <= mdr[7:0];
                r_disp_valid <= 1'b1;
                r_dsr_rdy    <= 1'b0;
            end else if (r_disp_valid && disp_ready) begin
                r_disp_valid <= 1'b0;
                r_dsr_rdy    <= 1'b1;
            end

            // run is sticky-low: a cleared MCR[15] can only come back through reset.
            if (w_mcr_wr)
                r_mcr <= {mdr[15] & r_mcr[15], mdr[14:0]};
        end
    end

`ifdef MMIO_IRQ_EN
    logic r_kb_ie;
    logic r_dsr_ie;
    logic r_irq;

    assign w_kb_ie  = r_kb_ie;
    assign w_dsr_ie = r_dsr_ie;
    assign irq      = r_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kb_ie  <= 1'b0;
            r_dsr_ie <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_dev_wr && (mar == KBSR_ADDR)) r_kb_ie  <= mdr[14];
            if (w_dev_wr && (mar == DSR_ADDR))  r_dsr_ie <= mdr[14];
            r_irq <= (r_kb_rdy & r_kb_ie) | (r_dsr_rdy & r_dsr_ie);
        end
    end
`else
    assign w_kb_ie  = 1'b0;
    assign w_dsr_ie = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_controller.sv
module tb_mmio_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mar, mdr;
    logic        mem_en, r_w;
    logic        mem_ready, mem_we;
    logic [1:0]  sel_mdr;
    logic [15:0] io_data;
    logic [7:0]  kb_data;
    logic        kb_valid;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready;
    logic        run;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    mmio_controller dut (
        .clk(clk), .reset(reset), .mar(mar), .mdr(mdr), .mem_en(mem_en), .r_w(r_w),
        .mem_ready(mem_ready), .mem_we(mem_we), .sel_mdr(sel_mdr), .io_data(io_data),
        .kb_data(kb_data), .kb_valid(kb_valid), .disp_data(disp_data), .disp_valid(disp_valid),
        .disp_ready(disp_ready), .run(run)
`ifdef MMIO_IRQ_EN
        , .irq(irq)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [15:0] data;
        bit          wr;
        logic [15:0] exp_io;
        logic [1:0]  exp_sel;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] io;
        logic [1:0]  sel;
        int          lat;
        int          we;
        bit          rd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One access: expectation queued at mem_en, popped and compared when mem_ready appears.
    task automatic access(input string name, input logic [15:0] a, input logic [15:0] d,
                          input bit wr, input logic [15:0] exp_io, input logic [1:0] exp_sel,
                          input int exp_lat, input bit kb_at_done = 1'b0,
                          input logic [7:0] kb_ch = 8'h00);
        exp_t e, got;
        int   lat, we_cnt;
        bit   seen;
        @(posedge clk); #1;
        mar = a; mdr = d; r_w = wr; mem_en = 1'b1;
        e.io = exp_io; e.sel = exp_sel; e.lat = exp_lat; e.rd = !wr;
        e.we = (wr && exp_sel == 2'b01) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk); #1;
        mem_en = 1'b0;
        lat = 0; we_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (mem_we) we_cnt++;
            if (mem_ready) begin
                seen = 1'b1;
                got = sb.pop_front();
                chk({name, " latency"}, lat, got.lat);
                chk({name, " sel_mdr"}, {30'b0, sel_mdr}, {30'b0, got.sel});
                if (got.rd) chk({name, " io_data"}, {16'b0, io_data}, {16'b0, got.io});
                chk({name, " mem_we cycles"}, we_cnt, got.we);
                if (kb_at_done) begin
                    kb_data = kb_ch; kb_valid = 1'b1;
                end
            end
        end
        chk({name, " ready seen"}, {31'b0, seen}, 32'd1);
        if (!seen) sb.delete();
        @(posedge clk); #1;
        kb_valid = 1'b0;
        @(negedge clk);
        chk({name, " ready one cycle"}, {30'b0, mem_ready, mem_we}, 32'd0);
    endtask

    task automatic kb_pulse(input logic [7:0] ch);
        @(posedge clk); #1;
        kb_data = ch; kb_valid = 1'b1;
        @(posedge clk); #1;
        kb_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b0; mar = '0; mdr = '0; mem_en = 1'b0; r_w = 1'b0;
        kb_data = '0; kb_valid = 1'b0; disp_ready = 1'b0;

        vecs[0] = '{"rd DSR",    16'hFE04, 16'h0000, 1'b0, 16'h8000, 2'b11, 1};
        vecs[1] = '{"rd MCR",    16'hFFFE, 16'h0000, 1'b0, 16'h8000, 2'b11, 1};
        vecs[2] = '{"rd KBSR",   16'hFE00, 16'h0000, 1'b0, 16'h0000, 2'b11, 1};
        vecs[3] = '{"rd KBDR",   16'hFE02, 16'h0000, 1'b0, 16'h0000, 2'b11, 1};
        vecs[4] = '{"rd DDR",    16'hFE06, 16'h0000, 1'b0, 16'h0000, 2'b11, 1};
        vecs[5] = '{"wr RAM",    16'h3000, 16'h1234, 1'b1, 16'h0000, 2'b01, 2};
        vecs[6] = '{"rd RAM",    16'h3000, 16'h0000, 1'b0, 16'h0000, 2'b01, 2};
        vecs[7] = '{"rd FE08",   16'hFE08, 16'h0000, 1'b0, 16'h0000, 2'b01, 2};
        vecs[8] = '{"rd FFFC",   16'hFFFC, 16'h0000, 1'b0, 16'h0000, 2'b01, 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst mem_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst sel_mdr", {30'b0, sel_mdr}, 32'd1);
        chk("rst io_data", {16'b0, io_data}, 32'd0);
        chk("rst disp", {23'b0, disp_valid, disp_data}, 32'd0);
        chk("rst run", {31'b0, run}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (vecs[i])
            access(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].wr,
                   vecs[i].exp_io, vecs[i].exp_sel, vecs[i].exp_lat);

        // Keyboard
        kb_pulse(8'h41);
        access("kb KBSR set", 16'hFE00, 16'h0, 1'b0, 16'h8000, 2'b11, 1);
        kb_pulse(8'h42);
        access("kb KBDR keep", 16'hFE02, 16'h0, 1'b0, 16'h0041, 2'b11, 1);
        access("kb KBSR clr", 16'hFE00, 16'h0, 1'b0, 16'h0000, 2'b11, 1);
        kb_pulse(8'h43);
        access("kb KBDR race", 16'hFE02, 16'h0, 1'b0, 16'h0043, 2'b11, 1, 1'b1, 8'h44);
        access("kb set wins", 16'hFE00, 16'h0, 1'b0, 16'h8000, 2'b11, 1);
        access("kb new char", 16'hFE02, 16'h0, 1'b0, 16'h0044, 2'b11, 1);
        access("kb KBSR clr2", 16'hFE00, 16'h0, 1'b0, 16'h0000, 2'b11, 1);
        access("wr KBSR ign", 16'hFE00, 16'h8000, 1'b1, 16'h0000, 2'b11, 1);
        access("KBSR after wr", 16'hFE00, 16'h0, 1'b0, 16'h0000, 2'b11, 1);

        // Display
        access("wr DDR 58", 16'hFE06, 16'h0058, 1'b1, 16'h0000, 2'b11, 1);
        chk("disp data 58", {24'b0, disp_data}, 32'h58);
        chk("disp valid", {31'b0, disp_valid}, 32'd1);
        access("DSR busy", 16'hFE04, 16'h0, 1'b0, 16'h0000, 2'b11, 1);
        access("wr DDR busy", 16'hFE06, 16'h0059, 1'b1, 16'h0000, 2'b11, 1);
        chk("disp busy ign", {23'b0, disp_valid, disp_data}, 32'h158);
        @(posedge clk); #1;
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
        @(negedge clk);
        chk("disp accepted", {31'b0, disp_valid}, 32'd0);
        access("DSR ready", 16'hFE04, 16'h0, 1'b0, 16'h8000, 2'b11, 1);
        access("wr DDR 5A", 16'hFE06, 16'h005A, 1'b1, 16'h0000, 2'b11, 1);
        chk("disp data 5A", {23'b0, disp_valid, disp_data}, 32'h15A);
        @(posedge clk); #1;
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;

`ifdef MMIO_IRQ_EN
        access("wr KBSR IE", 16'hFE00, 16'h4000, 1'b1, 16'h0000, 2'b11, 1);
        chk("irq idle", {31'b0, irq}, 32'd0);
        kb_pulse(8'h55);
        repeat (2) @(negedge clk);
        chk("irq set", {31'b0, irq}, 32'd1);
        access("KBSR ie", 16'hFE00, 16'h0, 1'b0, 16'hC000, 2'b11, 1);
        access("KBDR irq", 16'hFE02, 16'h0, 1'b0, 16'h0055, 2'b11, 1);
        repeat (2) @(negedge clk);
        chk("irq clr", {31'b0, irq}, 32'd0);
`else
        access("wr KBSR IE", 16'hFE00, 16'h4000, 1'b1, 16'h0000, 2'b11, 1);
        access("KBSR no ie", 16'hFE00, 16'h0, 1'b0, 16'h0000, 2'b11, 1);
`endif

        // MCR
        access("wr MCR 0", 16'hFFFE, 16'h0000, 1'b1, 16'h0000, 2'b11, 1);
        chk("run cleared", {31'b0, run}, 32'd0);
        access("wr MCR 8000", 16'hFFFE, 16'h8000, 1'b1, 16'h0000, 2'b11, 1);
        chk("run sticky", {31'b0, run}, 32'd0);
        access("rd MCR 0", 16'hFFFE, 16'h0, 1'b0, 16'h0000, 2'b11, 1);

        // Reset while a RAM write sits in WAIT
        @(posedge clk); #1;
        mar = 16'h3000; mdr = 16'hBEEF; r_w = 1'b1; mem_en = 1'b1;
        @(posedge clk); #1;
        mem_en = 1'b0; reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we || mem_ready) bad++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we || mem_ready) bad++;
        end
        chk("abort no we/ready", bad, 0);
        chk("abort run", {31'b0, run}, 32'd1);
        access("post rst DSR", 16'hFE04, 16'h0, 1'b0, 16'h8000, 2'b11, 1);
        access("post rst MCR", 16'hFFFE, 16'h0, 1'b0, 16'h8000, 2'b11, 1);
        access("post rst RAM", 16'h4000, 16'h0, 1'b0, 16'h0000, 2'b01, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
